instr_fetch_unit: RTL and testbench

- Producer end of the decode interface: fetches 16-bit instruction words from synchronous instruction memory and buffers them in a small FIFO.
- Presents each word to the logic controller split into opcode / Rdest / functionCode / Rsrc fields, using a valid/ready handshake.
- Handles redirects from branch and jump resolution by flushing buffered and in-flight words.
- Sits between instruction memory and the logic controller.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: prefetches 16-bit words into a small FIFO and presents decoded fields.
// Optional PREDECODE_EN adds a per-entry control-flow flag on output is_ctrl.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_BITS = 16,
  parameter int unsigned          OPBITS    = 4,
  parameter int unsigned          FUNCTBITS = 4,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 imem_rd_en,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [15:0]          imem_data,
  input  logic                 redirect,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [OPBITS-1:0]    opcode,
  output logic [3:0]           rdest,
  output logic [FUNCTBITS-1:0] functionCode,
  output logic [3:0]           rsrc,
  output logic [ADDR_BITS-1:0] dec_pc
`ifdef PREDECODE_EN
  ,
  output logic                 is_ctrl
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] fetch_pc_q;
  logic [ADDR_BITS-1:0] inflight_pc_q;
  logic                 inflight_q;
  logic [15:0]          instr_q [DEPTH];
  logic [ADDR_BITS-1:0] pc_q    [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic            running;
  logic            flush_req;
  logic            push;
  logic            pop;
  logic            issue;
  logic [CntW-1:0] credit;
  logic [15:0]     head;

  assign running   = (state_q == StRun);
  assign flush_req = redirect && (state_q != StIdle);
  assign dec_valid = (count_q != '0) && (state_q != StFlush);
  assign pop       = dec_valid && dec_ready;
  // A word returning in the redirect cycle belongs to the old stream and is dropped.
  assign push      = inflight_q && running && !redirect;
  // Same-cycle pop frees a slot, so a full FIFO can refill without a bubble.
  assign credit    = count_q + CntW'(inflight_q) - CntW'(pop);
  assign issue     = running && !redirect && (credit < DepthCnt);

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc_q;

  assign head         = instr_q[rd_ptr_q];
  assign opcode       = head[15 -: OPBITS];
  assign rdest        = head[11:8];
  assign functionCode = head[7 -: FUNCTBITS];
  assign rsrc         = head[3:0];
  assign dec_pc       = pc_q[rd_ptr_q];

`ifdef PREDECODE_EN
  logic ctrl_q [DEPTH];
  logic new_ctrl;

  always_comb begin
    new_ctrl = 1'b0;
    unique case (imem_data[15:12])
      4'hC, 4'hF, 4'h7: new_ctrl = 1'b1;
      4'h4:             new_ctrl = imem_data[7];
      default:          new_ctrl = 1'b0;
    endcase
  end

  assign is_ctrl = dec_valid && ctrl_q[rd_ptr_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
`ifdef PREDECODE_EN
        ctrl_q[i]  <= 1'b0;
`endif
      end
    end else begin
      case (state_q)
        StIdle:  if (start) state_q <= StRun;
        StRun:   if (redirect) state_q <= StFlush;
        StFlush: if (!redirect) state_q <= StRun;
        default: state_q <= StIdle;
      endcase

      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end

      if (flush_req) begin
        fetch_pc_q <= redirect_pc;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + ADDR_BITS'(1);
      end

      if (push) begin
        instr_q[wr_ptr_q] <= imem_data;
        pc_q[wr_ptr_q]    <= inflight_pc_q;
`ifdef PREDECODE_EN
        ctrl_q[wr_ptr_q]  <= new_ctrl;
`endif
      end

      if (flush_req) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus reset, stall and wrap sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  opcode;
  logic [3:0]  rdest;
  logic [3:0]  functionCode;
  logic [3:0]  rsrc;
  logic [15:0] dec_pc;
  logic        is_ctrl;

  logic        start2;
  logic        imem_rd_en2;
  logic [15:0] imem_addr2;
  logic [15:0] imem_data2;
  logic        redirect2;
  logic [15:0] redirect_pc2;
  logic        dec_valid2;
  logic        dec_ready2;
  logic [3:0]  opcode2;
  logic [3:0]  rdest2;
  logic [3:0]  functionCode2;
  logic [3:0]  rsrc2;
  logic [15:0] dec_pc2;
  logic        is_ctrl2;

  int total_cnt;
  int pass_cnt;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .opcode       (opcode),
    .rdest        (rdest),
    .functionCode (functionCode),
    .rsrc         (rsrc),
`ifdef PREDECODE_EN
    .dec_pc       (dec_pc),
    .is_ctrl      (is_ctrl)
`else
    .dec_pc       (dec_pc)
`endif
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start2),
    .imem_rd_en   (imem_rd_en2),
    .imem_addr    (imem_addr2),
    .imem_data    (imem_data2),
    .redirect     (redirect2),
    .redirect_pc  (redirect_pc2),
    .dec_valid    (dec_valid2),
    .dec_ready    (dec_ready2),
    .opcode       (opcode2),
    .rdest        (rdest2),
    .functionCode (functionCode2),
    .rsrc         (rsrc2),
`ifdef PREDECODE_EN
    .dec_pc       (dec_pc2),
    .is_ctrl      (is_ctrl2)
`else
    .dec_pc       (dec_pc2)
`endif
  );

`ifndef PREDECODE_EN
  assign is_ctrl  = 1'b0;
  assign is_ctrl2 = 1'b0;
`endif

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0080: return 16'hC123;
      16'h0081: return 16'h0453;
      16'h0082: return 16'h4980;
      16'h0083: return 16'h4370;
      default:  return 16'h5000 + a;
    endcase
  endfunction

  // Synchronous instruction memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem_word(imem_addr);
    if (imem_rd_en2) imem_data2 <= mem_word(imem_addr2);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic        start;
    logic        redirect;
    logic [15:0] rpc;
    logic        ready;
    logic        rd_en;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        ctrl;
  } vec_t;

  function automatic vec_t v(input logic s, input logic r, input logic [15:0] rpc,
                             input logic rdy, input logic en, input logic [15:0] a,
                             input logic vld, input logic [15:0] pc, input logic [15:0] ins,
                             input logic c);
    vec_t t;
    t.start = s; t.redirect = r; t.rpc = rpc; t.ready = rdy;
    t.rd_en = en; t.addr = a; t.valid = vld; t.pc = pc; t.instr = ins; t.ctrl = c;
    return t;
  endfunction

  vec_t vecs [32];
  int   rd_count;

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    start2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; dec_ready2 = 1'b1;

    vecs[0]  = v(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[1]  = v(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[2]  = v(0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0);
    vecs[3]  = v(0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 16'h5000, 0);
    vecs[4]  = v(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0001, 16'h5001, 0);
    vecs[5]  = v(0, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0002, 16'h5002, 0);
    vecs[6]  = v(0, 0, 16'h0000, 0, 1, 16'h0005, 1, 16'h0002, 16'h5002, 0);
    vecs[7]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 16'h5002, 0);
    vecs[8]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 16'h5002, 0);
    vecs[9]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 16'h5002, 0);
    vecs[10] = v(0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0002, 16'h5002, 0);
    vecs[11] = v(0, 0, 16'h0000, 1, 1, 16'h0007, 1, 16'h0003, 16'h5003, 0);
    vecs[12] = v(0, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0004, 16'h5004, 0);
    vecs[13] = v(0, 1, 16'h0040, 1, 0, 16'h0000, 1, 16'h0005, 16'h5005, 0);
    vecs[14] = v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[15] = v(0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0);
    vecs[16] = v(0, 0, 16'h0000, 1, 1, 16'h0041, 0, 16'h0000, 16'h0000, 0);
    vecs[17] = v(0, 1, 16'h0010, 1, 0, 16'h0000, 1, 16'h0040, 16'h5040, 0);
    vecs[18] = v(0, 1, 16'h0020, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[19] = v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[20] = v(0, 0, 16'h0000, 1, 1, 16'h0020, 0, 16'h0000, 16'h0000, 0);
    vecs[21] = v(1, 0, 16'h0000, 1, 1, 16'h0021, 0, 16'h0000, 16'h0000, 0);
    vecs[22] = v(0, 0, 16'h0000, 1, 1, 16'h0022, 1, 16'h0020, 16'h5020, 0);
    vecs[23] = v(0, 0, 16'h0000, 1, 1, 16'h0023, 1, 16'h0021, 16'h5021, 0);
    vecs[24] = v(0, 1, 16'h0080, 1, 0, 16'h0000, 1, 16'h0022, 16'h5022, 0);
    vecs[25] = v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[26] = v(0, 0, 16'h0000, 1, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0);
    vecs[27] = v(0, 0, 16'h0000, 1, 1, 16'h0081, 0, 16'h0000, 16'h0000, 0);
    vecs[28] = v(0, 0, 16'h0000, 1, 1, 16'h0082, 1, 16'h0080, 16'hC123, 1);
    vecs[29] = v(0, 0, 16'h0000, 1, 1, 16'h0083, 1, 16'h0081, 16'h0453, 0);
    vecs[30] = v(0, 0, 16'h0000, 1, 1, 16'h0084, 1, 16'h0082, 16'h4980, 1);
    vecs[31] = v(0, 0, 16'h0000, 1, 1, 16'h0085, 1, 16'h0083, 16'h4370, 0);

    #1 rst_n = 1'b0;
    #1;
    check("reset rd_en", 32'(imem_rd_en), 32'd0);
    check("reset valid", 32'(dec_valid), 32'd0);
    check("reset dec_pc", 32'(dec_pc), 32'd0);
    check("reset fields", {16'd0, opcode, rdest, functionCode, rsrc}, 32'd0);
    check("reset addr", 32'(imem_addr), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      vec_t t;
      t = vecs[i];
      next_cycle();
      start = t.start; redirect = t.redirect; redirect_pc = t.rpc; dec_ready = t.ready;
      #1;
      check($sformatf("c%0d rd_en", i), 32'(imem_rd_en), 32'(t.rd_en));
      if (t.rd_en) check($sformatf("c%0d addr", i), 32'(imem_addr), 32'(t.addr));
      check($sformatf("c%0d valid", i), 32'(dec_valid), 32'(t.valid));
      if (t.valid) begin
        check($sformatf("c%0d dec_pc", i), 32'(dec_pc), 32'(t.pc));
        check($sformatf("c%0d fields", i), 32'({opcode, rdest, functionCode, rsrc}),
              32'(t.instr));
`ifdef PREDECODE_EN
        check($sformatf("c%0d is_ctrl", i), 32'(is_ctrl), 32'(t.ctrl));
`endif
      end
    end

    // Asynchronous reset in the middle of a stream.
    next_cycle();
    start = 1'b0; redirect = 1'b0; dec_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid reset rd_en", 32'(imem_rd_en), 32'd0);
    check("mid reset valid", 32'(dec_valid), 32'd0);
    check("mid reset dec_pc", 32'(dec_pc), 32'd0);
    check("mid reset fields", 32'({opcode, rdest, functionCode, rsrc}), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0070;
    #1;
    check("idle redirect rd_en", 32'(imem_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      redirect = 1'b0;
      #1;
      check($sformatf("idle%0d valid", i), 32'(dec_valid), 32'd0);
      check($sformatf("idle%0d rd_en", i), 32'(imem_rd_en), 32'd0);
    end

    // Restart with consumer stalled: FIFO fills to DEPTH then issue stops.
    next_cycle();
    start = 1'b1; dec_ready = 1'b0;
    rd_count = 0;
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      start = 1'b0;
      #1;
      if (imem_rd_en) begin
        check($sformatf("stall%0d addr", i), 32'(imem_addr), 32'(rd_count));
        rd_count++;
      end
      if (i == 3) check("first valid after restart", 32'(dec_valid), 32'd1);
    end
    check("stall read count", 32'(rd_count), 32'd4);
    check("stall rd_en low", 32'(imem_rd_en), 32'd0);
    check("stall holds word0 pc", 32'(dec_pc), 32'd0);
    check("stall holds word0 op", 32'({opcode, rdest, functionCode, rsrc}), 32'h5000);

    for (int k = 0; k < 5; k++) begin
      next_cycle();
      dec_ready = 1'b1;
      #1;
      check($sformatf("drain%0d valid", k), 32'(dec_valid), 32'd1);
      check($sformatf("drain%0d dec_pc", k), 32'(dec_pc), 32'(k));
      if (k == 0) begin
        check("resume rd_en", 32'(imem_rd_en), 32'd1);
        check("resume addr", 32'(imem_addr), 32'd4);
      end
    end

    // Wrap of the fetch address from RESET_PC = FFFE.
    next_cycle();
    start2 = 1'b1;
    #1;
    check("wrap w0 rd_en", 32'(imem_rd_en2), 32'd0);
    for (int w = 1; w <= 5; w++) begin
      next_cycle();
      start2 = 1'b0;
      #1;
      if (w <= 3) begin
        check($sformatf("wrap w%0d rd_en", w), 32'(imem_rd_en2), 32'd1);
        check($sformatf("wrap w%0d addr", w), 32'(imem_addr2), 32'((16'hFFFE + w - 1) & 16'hFFFF));
      end
      if (w >= 3) begin
        check($sformatf("wrap w%0d valid", w), 32'(dec_valid2), 32'd1);
        check($sformatf("wrap w%0d dec_pc", w), 32'(dec_pc2), 32'((16'hFFFE + w - 3) & 16'hFFFF));
      end
      if (w == 3) begin
`ifdef PREDECODE_EN
        check("wrap is_ctrl", 32'(is_ctrl2), 32'd1);
`endif
      end
      if (w == 4) check("wrap fields", 32'({opcode2, rdest2, functionCode2, rsrc2}), 32'h4FFF);
      if (w == 5) check("wrap word0 op", 32'(opcode2), 32'd5);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
